// File: rtl/rv32i_pkg.sv
// Shared RV32I datapath types and constants.
package rv32i_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [XLEN-1:0]       word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : rv32i_pkg

// File: rtl/reg_file_rport.sv
// One read port of the integer register file: x0 forcing, stored-value and
// pending lookup, and (with REG_FILE_BYPASS_EN defined) write-to-read bypass.
// Outputs are held at 0 while reset is asserted, so a write or issue that is
// presented during reset can never leak through the bypass path.
module reg_file_rport
    import rv32i_pkg::*;
#(
    parameter int XLEN = rv32i_pkg::XLEN,
    parameter int NREG = 32
) (
    input  logic                              rst_n,
    input  logic [rv32i_pkg::REG_ADDR_W-1:0]  addr,
    input  logic [XLEN-1:0]                   rf [NREG],
    input  logic [NREG-1:0]                   pend,
    input  logic                              we,
    input  logic [rv32i_pkg::REG_ADDR_W-1:0]  waddr,
    input  logic [XLEN-1:0]                   wdata,
    input  logic                              issue_en,
    input  logic [rv32i_pkg::REG_ADDR_W-1:0]  issue_rd,
    output logic [XLEN-1:0]                   rdata,
    output logic                              rpend
);

    logic [XLEN-1:0] data_sel;
    logic            pend_sel;

`ifdef REG_FILE_BYPASS_EN
    logic hit;

    assign hit = we && (waddr != '0) && (waddr == addr);

    // Bypass: a write in flight to this address is forwarded; pending reads
    // clear unless a new issue to the same register lands in this cycle.
    always_comb begin
        data_sel = rf[addr];
        pend_sel = pend[addr];
        if (hit) begin
            data_sel = wdata;
            pend_sel = issue_en && (issue_rd == addr);
        end
    end
`else
    logic unused_bypass_inputs;

    assign unused_bypass_inputs = &{1'b0, we, waddr, wdata, issue_en, issue_rd};

    // No bypass: stored value and stored pending bit only.
    always_comb begin
        data_sel = rf[addr];
        pend_sel = pend[addr];
    end
`endif

    // x0 is hard-wired zero and never pending; everything reads 0 in reset.
    always_comb begin
        rdata = '0;
        rpend = 1'b0;
        if (rst_n && (addr != '0)) begin
            rdata = data_sel;
            rpend = pend_sel;
        end
    end

endmodule : reg_file_rport

// File: rtl/reg_file.sv
// RV32I integer register file: 32 x XLEN registers, two combinational read
// ports, one synchronous write port and a per-register pending bit used by
// the hazard logic. Define REG_FILE_BYPASS_EN for same-cycle write-to-read
// forwarding.
module reg_file
#(
    parameter int XLEN = rv32i_pkg::XLEN,
    parameter int NREG = 32
) (
    input  logic                              CLK,
    input  logic                              RST_N,
    input  logic [rv32i_pkg::REG_ADDR_W-1:0]  A1,
    input  logic [rv32i_pkg::REG_ADDR_W-1:0]  A2,
    output logic [XLEN-1:0]                   RD1,
    output logic [XLEN-1:0]                   RD2,
    input  logic [rv32i_pkg::REG_ADDR_W-1:0]  A3,
    input  logic [XLEN-1:0]                   WD3,
    input  logic                              WE3,
    input  logic                              ISSUE_EN,
    input  logic [rv32i_pkg::REG_ADDR_W-1:0]  ISSUE_RD,
    output logic                              PEND1,
    output logic                              PEND2
);

    import rv32i_pkg::*;

    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [NREG-1:1] pend_q;
    logic [XLEN-1:0] rf_view [NREG];
    logic [NREG-1:0] pend_view;

    // Architectural registers x1..x31; a write to x0 is dropped.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int r = 1; r < NREG; r++) regs_q[r] <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (WE3 && (A3 == reg_addr_t'(r))) regs_q[r] <= WD3;
            end
        end
    end

    // Pending bits: issue sets, writeback clears, and a coincident issue wins
    // because it represents a newer outstanding writer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend_q <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (ISSUE_EN && (ISSUE_RD == reg_addr_t'(r))) begin
                    pend_q[r] <= 1'b1;
                end else if (WE3 && (A3 == reg_addr_t'(r))) begin
                    pend_q[r] <= 1'b0;
                end
            end
        end
    end

    // Full-width views with x0 tied off, shared by both read ports.
    always_comb begin
        rf_view[0] = '0;
        for (int r = 1; r < NREG; r++) rf_view[r] = regs_q[r];
    end

    assign pend_view = {pend_q, 1'b0};

    reg_file_rport #(.XLEN(XLEN), .NREG(NREG)) u_rport1 (
        .rst_n    (RST_N),
        .addr     (A1),
        .rf       (rf_view),
        .pend     (pend_view),
        .we       (WE3),
        .waddr    (A3),
        .wdata    (WD3),
        .issue_en (ISSUE_EN),
        .issue_rd (ISSUE_RD),
        .rdata    (RD1),
        .rpend    (PEND1)
    );

    reg_file_rport #(.XLEN(XLEN), .NREG(NREG)) u_rport2 (
        .rst_n    (RST_N),
        .addr     (A2),
        .rf       (rf_view),
        .pend     (pend_view),
        .we       (WE3),
        .waddr    (A3),
        .wdata    (WD3),
        .issue_en (ISSUE_EN),
        .issue_rd (ISSUE_RD),
        .rdata    (RD2),
        .rpend    (PEND2)
    );

endmodule : reg_file
